// File: rtl/tenv_wishbone_master_pkg.sv
// Shared types for the test-environment Wishbone initiator: FSM state encoding
// and watchdog counter width.
package tenv_wishbone_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } wb_state_e;

  localparam int WDOG_W = 16;

endpackage

// File: rtl/tenv_wb_watchdog.sv
// Cycle counter for the Wishbone initiator; clears while idle, counts while
// enabled, and flags terminal count at TIMEOUT-1.
module tenv_wb_watchdog
  import tenv_wishbone_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/tenv_wishbone_master.sv
// Single-outstanding pipelined Wishbone initiator: one host request becomes one
// cyc/stb transfer, with a watchdog that ends the cycle with err_o if no ack arrives.
module tenv_wishbone_master
  import tenv_wishbone_master_pkg::*;
#(
  parameter int WADDR   = 10,
  parameter int WDATA   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               req_we_i,
  input  logic [3:0]         req_sel_i,
  input  logic [WADDR-1:0]   req_adr_i,
  input  logic [WDATA*4-1:0] req_dat_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [WDATA*4-1:0] rdata_o,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  output logic [3:0]         sel_o,
  output logic [WADDR-1:0]   adr_o,
  output logic [WDATA*4-1:0] dat_o,
  input  logic               stall_i,
  input  logic               ack_i,
  input  logic [WDATA*4-1:0] dat_i
);

  localparam int DW = WDATA * 4;

  wb_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [WADDR-1:0] adr_q, adr_d;
  logic [DW-1:0]    dat_q, dat_d;

  logic wd_clr, wd_tc;
  logic ack_ok, tmo;

  tenv_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wd_clr),
    .en_i  (cyc_q),
    .tc_o  (wd_tc)
  );

  assign wd_clr = (state_q == ST_IDLE);

  // A stalled ack is not a qualifying ack; it wins over the watchdog only when qualifying.
  assign ack_ok = ((state_q == ST_REQ) && !stall_i && ack_i) ||
                  ((state_q == ST_WAIT) && ack_i);
  assign tmo    = (state_q != ST_IDLE) && wd_tc && !ack_ok;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (ack_ok) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d = dat_i;
          end
        end else if (tmo) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if ((state_q == ST_REQ) && !stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = stb_q;
  assign we_o    = we_q;
  assign sel_o   = sel_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;

endmodule

// File: tb/tb_tenv_wishbone_master.sv
// Scoreboard bench for tenv_wishbone_master with a settable-latency 4-lane
// memory responder; completions are checked by an independent monitor.
module tb_tenv_wishbone_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, req_we_i;
  logic [3:0]  req_sel_i;
  logic [9:0]  req_adr_i;
  logic [31:0] req_dat_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [9:0]  adr_o;
  logic [31:0] dat_o;
  logic        stall_i, ack_i;
  logic [31:0] dat_i;

  always #5 clk_i = ~clk_i;

  tenv_wishbone_master #(
    .WADDR(10), .WDATA(8), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_we_i(req_we_i), .req_sel_i(req_sel_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o),
    .stall_i(stall_i), .ack_i(ack_i), .dat_i(dat_i)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          access_time = 1;
  bit          noack = 1'b0;
  logic [31:0] mem [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responder: decides stall/ack at each falling edge for the next rising edge.
  initial begin : responder
    bit          ack_pend;
    int          stall_cnt;
    logic [31:0] rd_lat;
    ack_pend = 1'b0; stall_cnt = 0; rd_lat = '0;
    stall_i = 1'b0; ack_i = 1'b0; dat_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(negedge clk_i);
      stall_i = 1'b0;
      ack_i   = 1'b0;
      if (!rst_i) begin
        ack_pend = 1'b0;
        stall_cnt = 0;
      end else begin
        if (ack_pend) begin
          ack_i = 1'b1;
          dat_i = rd_lat;
          ack_pend = 1'b0;
        end
        if (cyc_o && stb_o && !noack) begin
          if (access_time <= 1 || stall_cnt >= access_time - 1) begin
            if (we_o) begin
              for (int b = 0; b < 4; b++)
                if (sel_o[b]) mem[adr_o][b*8 +: 8] = dat_o[b*8 +: 8];
            end
            rd_lat = mem[adr_o];
            stall_cnt = 0;
            if (access_time <= 1) begin
              ack_pend = 1'b1;
            end else begin
              ack_i = 1'b1;
              dat_i = rd_lat;
            end
          end else begin
            stall_i = 1'b1;
            stall_cnt++;
          end
        end else if (!cyc_o) begin
          stall_cnt = 0;
        end
      end
    end
  end

  // Monitor: every completion must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_i);
      if (err_o && !done_o) chk("err_without_done", 32'(err_o), 32'(done_o));
      if (done_o && prev_done) chk("done_single_pulse", 32'(prev_done), 32'd0);
      if (done_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("done_err", 32'(err_o), 32'(e.err));
          chk("done_rdata", rdata_o, e.rdata);
        end
      end
      prev_done = done_o;
    end
  end

  task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [9:0] adr,
                          input logic [31:0] dat, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat,
                          input bit chk_stable, input bit poke_busy, input string name);
    int         lat, cyc_hi;
    bit         seen;
    logic [9:0] saved_adr;
    @(negedge clk_i);
    req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = dat; req_i = 1'b1;
    sb_q.push_back('{err: exp_err, rdata: exp_rd});
    @(posedge clk_i);
    #1 req_i = 1'b0;
    lat = 0; cyc_hi = 0; seen = 1'b0;
    @(negedge clk_i);
    saved_adr = adr_o;
    chk({name, "_adr"}, 32'(adr_o), 32'(adr));
    while (!seen && lat < 100) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (cyc_o) cyc_hi++;
        if (chk_stable) begin
          chk({name, "_stb_held"}, {30'd0, cyc_o, stb_o}, 32'd3);
          chk({name, "_adr_held"}, 32'(adr_o), 32'(saved_adr));
        end
        if (poke_busy && lat == 1) begin
          req_adr_i = adr ^ 10'h1; req_i = 1'b1;
        end
        if (poke_busy && lat == 2) req_i = 1'b0;
        @(negedge clk_i);
        lat++;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_cyc_cycles"}, 32'(cyc_hi), 32'(exp_lat));
  endtask

  initial begin : stim
    int rises, dones, gap, extra;
    bit prev_cyc, seen;
    rst_i = 1'b0; req_i = 1'b0; req_we_i = 1'b0; req_sel_i = '0;
    req_adr_i = '0; req_dat_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", {26'd0, busy_o, done_o, err_o, cyc_o, stb_o, we_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bus", {8'd0, sel_o, adr_o, 10'd0} | 32'(dat_o), 32'd0);
    rst_i = 1'b1;

    access_time = 1; noack = 1'b0;
    run_xfer(1'b1, 4'hF, 10'd3, 32'hA5A5_1234, 1'b0, 32'h0, 2, 1'b0, 1'b0, "t1_wr");
    run_xfer(1'b0, 4'hF, 10'd3, 32'h0, 1'b0, 32'hA5A5_1234, 2, 1'b0, 1'b0, "t1_rd");

    run_xfer(1'b1, 4'b0010, 10'd3, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_1234, 2, 1'b0, 1'b0, "t2_wr");
    run_xfer(1'b0, 4'hF, 10'd3, 32'h0, 1'b0, 32'hA5A5_FF34, 2, 1'b0, 1'b0, "t2_rd");

    access_time = 4;
    run_xfer(1'b0, 4'hF, 10'd3, 32'h0, 1'b0, 32'hA5A5_FF34, 4, 1'b1, 1'b1, "t3_stall");

    noack = 1'b1;
    run_xfer(1'b0, 4'hF, 10'd7, 32'h0, 1'b1, 32'hA5A5_FF34, 16, 1'b0, 1'b0, "t4_tmo");

    // Back-to-back: req_i held for three transfers, then dropped while busy.
    access_time = 1; noack = 1'b0;
    @(negedge clk_i);
    req_we_i = 1'b0; req_sel_i = 4'hF; req_adr_i = 10'd3; req_i = 1'b1;
    repeat (3) sb_q.push_back('{err: 1'b0, rdata: 32'hA5A5_FF34});
    rises = 0; dones = 0; gap = 0; prev_cyc = 1'b0;
    for (int n = 0; n < 60 && dones < 3; n++) begin
      @(negedge clk_i);
      if (cyc_o && !prev_cyc) begin
        rises++;
        if (rises > 1) chk("t5_gap", 32'(gap), 32'd1);
        gap = 0;
        if (rises == 3) req_i = 1'b0;
      end
      if (!cyc_o && rises > 0) gap++;
      if (done_o) dones++;
      prev_cyc = cyc_o;
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (cyc_o) extra++;
    end
    chk("t5_transfers", 32'(rises), 32'd3);
    chk("t5_dones", 32'(dones), 32'd3);
    chk("t5_no_extra", 32'(extra), 32'd0);

    // Reset in WAIT: no completion expected for this transfer.
    noack = 1'b1;
    @(negedge clk_i);
    req_we_i = 1'b1; req_sel_i = 4'hF; req_adr_i = 10'd9; req_dat_i = 32'h1234_5678; req_i = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk_i);
      if (cyc_o && !stb_o) seen = 1'b1;
    end
    chk("t6_reached_wait", 32'(seen), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_drop", {29'd0, cyc_o, stb_o, busy_o}, 32'd0);
    chk("t6_rst_nodone", {30'd0, done_o, err_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    chk("t6_rst_rdata", rdata_o, 32'd0);
    rst_i = 1'b1;
    noack = 1'b0;
    run_xfer(1'b0, 4'hF, 10'd3, 32'h0, 1'b0, 32'hA5A5_FF34, 2, 1'b0, 1'b0, "t6_after");

    repeat (4) @(negedge clk_i);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
